// File: rtl/mem_copy_engine.sv
// Block-transfer engine for the 16-bit program RAM: copies a region through the
// read-only second port into the primary port, or fills a region with a constant.
module mem_copy_engine #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_mode,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [ADDR_W:0]   i_len,
    input  logic [DATA_W-1:0] i_fill_data,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_ram_address,
    output logic [ADDR_W-1:0] o_ram_address2,
    output logic              o_ram_write,
    output logic              o_ram_read,
    output logic [DATA_W-1:0] o_ram_writedata,
    input  logic [DATA_W-1:0] i_ram_readdata2,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_mode;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_left;
    logic                r_busy;
    logic                r_done;
    logic                r_ram_write;
    logic                r_ram_read;
    logic [ADDR_W-1:0]   r_ram_address;
    logic [ADDR_W-1:0]   r_ram_address2;
    logic                r_wr_sel;
    logic [DATA_W-1:0]   r_fill_out;

    // Handshake: i_start is a request taken only in IDLE, together with every
    // other command input; o_done pulses once per accepted request, o_busy spans
    // the cycles in which the engine owns the RAM ports.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_mode         <= 1'b0;
            r_rd_ptr       <= '0;
            r_wr_ptr       <= '0;
            r_left         <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_ram_write    <= 1'b0;
            r_ram_read     <= 1'b0;
            r_ram_address  <= '0;
            r_ram_address2 <= '0;
            r_wr_sel       <= 1'b0;
            r_fill_out     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode <= i_mode;
                        if (i_len == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else if (!i_mode) begin
                            r_state        <= S_RUN;
                            r_busy         <= 1'b1;
                            r_ram_read     <= 1'b1;
                            r_ram_address2 <= i_src;
                            r_rd_ptr       <= i_src + 1'b1;
                            r_wr_ptr       <= i_dst;
                            r_left         <= i_len - 1'b1;
                        end else begin
                            r_state       <= S_RUN;
                            r_busy        <= 1'b1;
                            r_ram_write   <= 1'b1;
                            r_ram_address <= i_dst;
                            r_fill_out    <= i_fill_data;
                            r_wr_ptr      <= i_dst + 1'b1;
                            r_left        <= i_len - 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!r_mode) begin
                        // Every read is followed one cycle later by its write.
                        r_ram_write   <= 1'b1;
                        r_wr_sel      <= 1'b1;
                        r_ram_address <= r_wr_ptr;
                        r_wr_ptr      <= r_wr_ptr + 1'b1;
                        if (r_left != '0) begin
                            r_ram_address2 <= r_rd_ptr;
                            r_rd_ptr       <= r_rd_ptr + 1'b1;
                            r_left         <= r_left - 1'b1;
                        end else begin
                            r_state        <= S_DRAIN;
                            r_ram_read     <= 1'b0;
                            r_ram_address2 <= '0;
                        end
                    end else begin
                        if (r_left != '0) begin
                            r_ram_address <= r_wr_ptr;
                            r_wr_ptr      <= r_wr_ptr + 1'b1;
                            r_left        <= r_left - 1'b1;
                        end else begin
                            r_state       <= S_DONE;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                            r_ram_write   <= 1'b0;
                            r_ram_address <= '0;
                            r_fill_out    <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state       <= S_DONE;
                    r_done        <= 1'b1;
                    r_busy        <= 1'b0;
                    r_ram_write   <= 1'b0;
                    r_wr_sel      <= 1'b0;
                    r_ram_address <= '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_ram_address   = r_ram_address;
    assign o_ram_address2  = r_ram_address2;
    assign o_ram_write     = r_ram_write;
    assign o_ram_read      = r_ram_read;
    // Copy writes forward the RAM's registered read data unbuffered.
    assign o_ram_writedata = r_wr_sel ? i_ram_readdata2 : r_fill_out;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine with a behavioural read-old-on-collision
// dual-port RAM model.
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [11:0] src;
    logic [11:0] dst;
    logic [12:0] len;
    logic [15:0] fill_data;
    logic        busy;
    logic        done;
    logic [11:0] ram_address;
    logic [11:0] ram_address2;
    logic        ram_write;
    logic        ram_read;
    logic [15:0] ram_writedata;
    logic [15:0] ram_readdata2;
    logic [1:0]  dbg_state;

    logic [15:0] mem [0:4095];
    logic        pk_en;
    logic [11:0] pk_a;
    logic [15:0] pk_d;

    int n_checks = 0;
    int n_pass   = 0;

    int done_cyc, done_cnt, busy_cnt, busy_first, busy_last, rd_cnt, wr_cnt;
    logic [11:0] addr2_seen[$];
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(12), .DATA_W(16)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_start         (start),
        .i_mode          (mode),
        .i_src           (src),
        .i_dst           (dst),
        .i_len           (len),
        .i_fill_data     (fill_data),
        .o_busy          (busy),
        .o_done          (done),
        .o_ram_address   (ram_address),
        .o_ram_address2  (ram_address2),
        .o_ram_write     (ram_write),
        .o_ram_read      (ram_read),
        .o_ram_writedata (ram_writedata),
        .i_ram_readdata2 (ram_readdata2),
        .o_dbg_state     (dbg_state)
    );

    // RAM: second-port read returns the pre-write contents on a same-cycle collision.
    always @(posedge clk) begin
        if (pk_en)
            mem[pk_a] <= pk_d;
        else if (ram_write)
            mem[ram_address] <= ram_writedata;
        ram_readdata2 <= mem[ram_address2];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        @(posedge clk);
        #1;
        pk_en = 1'b0;
    endtask

    // Issues one request and observes a fixed window of len+6 cycles.
    task automatic xfer(input logic m, input logic [11:0] s, input logic [11:0] d,
                        input logic [12:0] n, input logic [15:0] f, input bit repulse);
        done_cyc = 0; done_cnt = 0; busy_cnt = 0; busy_first = 0; busy_last = 0;
        rd_cnt = 0; wr_cnt = 0;
        addr2_seen.delete();
        mode = m; src = s; dst = d; len = n; fill_data = f; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= int'(n) + 6; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (repulse && c == 2) begin
                start = 1'b1;
                src   = 12'h555;
                dst   = 12'h666;
            end
            if (repulse && c == 3) start = 1'b0;
            if (busy) begin
                busy_cnt++;
                if (busy_first == 0) busy_first = c;
                busy_last = c;
            end
            if (ram_read) begin
                rd_cnt++;
                addr2_seen.push_back(ram_address2);
            end
            if (ram_write) wr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
        end
    endtask

    initial begin
        bit saw_bad;
        reset = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
        fill_data = '0; pk_en = 1'b0; pk_a = '0; pk_d = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, ram_write, ram_read, ram_address, ram_address2, ram_writedata}, 64'd0);
        chk("reset_state", dbg_state, 2'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Plain copy
        for (int i = 0; i < 4; i++) poke(12'h010 + 12'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) poke(12'h100 + 12'(i), 16'h0000);
        xfer(1'b0, 12'h010, 12'h100, 13'd4, 16'h0, 1'b0);
        chk("copy_done_cycle", done_cyc, 6);
        chk("copy_done_count", done_cnt, 1);
        chk("copy_busy_span", {busy_cnt[7:0], busy_first[7:0], busy_last[7:0]}, {8'd5, 8'd1, 8'd5});
        chk("copy_reads", rd_cnt, 4);
        chk("copy_writes", wr_cnt, 4);
        chk("copy_dst", {mem[12'h100], mem[12'h101], mem[12'h102], mem[12'h103]}, 64'hA000_A001_A002_A003);
        chk("copy_src_kept", {mem[12'h010], mem[12'h011], mem[12'h012], mem[12'h013]}, 64'hA000_A001_A002_A003);

        // Address wrap
        poke(12'hFFE, 16'd1); poke(12'hFFF, 16'd2); poke(12'h000, 16'd3); poke(12'h001, 16'd4);
        xfer(1'b0, 12'hFFE, 12'h7FE, 13'd4, 16'h0, 1'b0);
        chk("wrap_dst", {mem[12'h7FE], mem[12'h7FF], mem[12'h800], mem[12'h801]}, 64'h0001_0002_0003_0004);
        exp_q.push_back(12'hFFE); exp_q.push_back(12'hFFF);
        exp_q.push_back(12'h000); exp_q.push_back(12'h001);
        chk("wrap_addr2_len", addr2_seen.size(), 4);
        for (int i = 0; i < 4 && i < addr2_seen.size(); i++) chk("wrap_addr2", addr2_seen[i], exp_q.pop_front());

        // Overlapping regions
        for (int i = 0; i < 4; i++) poke(12'h020 + 12'(i), 16'(i + 1));
        xfer(1'b0, 12'h020, 12'h021, 13'd3, 16'h0, 1'b0);
        chk("overlap_shift1", {mem[12'h020], mem[12'h021], mem[12'h022], mem[12'h023]}, 64'h0001_0001_0002_0003);
        for (int i = 0; i < 4; i++) poke(12'h020 + 12'(i), 16'(i + 1));
        xfer(1'b0, 12'h020, 12'h022, 13'd2, 16'h0, 1'b0);
        chk("overlap_shift2", {mem[12'h020], mem[12'h021], mem[12'h022], mem[12'h023]}, 64'h0001_0002_0001_0002);
        for (int i = 0; i < 6; i++) poke(12'h030 + 12'(i), 16'(i + 1));
        xfer(1'b0, 12'h030, 12'h032, 13'd4, 16'h0, 1'b0);
        chk("overlap_pattern", {mem[12'h032], mem[12'h033], mem[12'h034], mem[12'h035]}, 64'h0001_0002_0001_0002);

        // Fill
        poke(12'h305, 16'h1234);
        xfer(1'b1, 12'h000, 12'h300, 13'd5, 16'hBEEF, 1'b0);
        chk("fill_done_cycle", done_cyc, 6);
        chk("fill_busy_span", {busy_cnt[7:0], busy_first[7:0], busy_last[7:0]}, {8'd5, 8'd1, 8'd5});
        chk("fill_reads", rd_cnt, 0);
        chk("fill_writes", wr_cnt, 5);
        chk("fill_dst_lo", {mem[12'h300], mem[12'h301], mem[12'h302], mem[12'h303]}, 64'hBEEF_BEEF_BEEF_BEEF);
        chk("fill_dst_hi", {mem[12'h304], mem[12'h305]}, 32'hBEEF_1234);

        // Zero length
        xfer(1'b0, 12'h010, 12'h200, 13'd0, 16'h0, 1'b0);
        chk("len0_done_cycle", done_cyc, 1);
        chk("len0_activity", {busy_cnt[7:0], rd_cnt[7:0], wr_cnt[7:0]}, 24'd0);

        // Start re-pulsed mid-transfer
        for (int i = 0; i < 3; i++) poke(12'h040 + 12'(i), 16'h7000 + 16'(i));
        xfer(1'b0, 12'h040, 12'h140, 13'd3, 16'h0, 1'b1);
        chk("repulse_done_count", done_cnt, 1);
        chk("repulse_done_cycle", done_cyc, 5);
        chk("repulse_dst", {mem[12'h140], mem[12'h141], mem[12'h142]}, 48'h7000_7001_7002);

        // Reset mid-copy
        for (int i = 0; i < 8; i++) poke(12'h400 + 12'(i), 16'hC000 + 16'(i));
        for (int i = 0; i < 8; i++) poke(12'h500 + 12'(i), 16'h5555);
        mode = 1'b0; src = 12'h400; dst = 12'h500; len = 13'd8; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outputs", {busy, done, ram_write, ram_read, ram_address, ram_address2, ram_writedata}, 64'd0);
        reset = 1'b0;
        saw_bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done || busy || ram_write || ram_read) saw_bad = 1'b1;
        end
        chk("abort_quiet", saw_bad, 1'b0);
        chk("abort_written", {mem[12'h500], mem[12'h501]}, 32'hC000_C001);
        saw_bad = 1'b0;
        for (int i = 2; i < 8; i++) if (mem[12'h500 + 12'(i)] !== 16'h5555) saw_bad = 1'b1;
        chk("abort_untouched", saw_bad, 1'b0);
        xfer(1'b1, 12'h000, 12'h600, 13'd2, 16'h0F0F, 1'b0);
        chk("restart_done_cycle", done_cyc, 3);
        chk("restart_dst", {mem[12'h600], mem[12'h601]}, 32'h0F0F_0F0F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
